ex_mem_pipe_stage: RTL and testbench
====================================

# ex_mem_pipe_stage

- Parametrised EX→MEM pipeline stage for the 16-bit core: registers the execute-stage control bits, ALU result, store data and destination register, and presents them to the memory stage.
- Successor to the fixed-width, stall-only stage. Adds:
  - a valid/ready handshake with a 2-entry skid buffer, so downstream backpressure never propagates combinationally upstream;
  - a flush that turns in-flight entries into bubbles;
  - synchronous reset;
  - a forwarding tap back to EX.

## Interface
Parameters:
- DATA_W, 16, width of ALU result and store data
- REG_W, 8, width of the destination-register field

Ports:
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept; registered, depends only on occupancy
- in_mwe  in  1  memory write enable
- in_mux  in  1  writeback select (1 = memory data, 0 = ALU result)
- in_rwe  in  1  register write enable
- in_res  in  DATA_W  ALU result / memory address
- in_datb  in  DATA_W  store data
- in_creg  in  REG_W  destination register
- stall  in  1  global freeze
- flush  in  1  discard all held entries
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM consumes head this cycle
- out_mwe, out_rwe  out  1  head enables, gated by out_valid
- out_mux  out  1  head writeback select
- out_res, out_datb  out  DATA_W  head payload
- out_creg  out  REG_W  head destination register
- fwd_rwe  out  1  out_valid & head.rwe & ~head.mux
- fwd_reg  out  REG_W  equals out_creg
- fwd_data  out  DATA_W  equals out_res

## Operation
- Storage: main entry (head) and skid entry. Each entry holds {mwe, mux, rwe, res, datb, creg}.
- Accept when in_valid & in_ready & ~stall & ~flush.
- Drain when out_valid & out_ready & ~stall & ~flush.
- Occupancy FSM, states EMPTY, ONE, TWO:
  - EMPTY: accept → ONE, head ← input.
  - ONE: accept & ~drain → TWO, skid ← input.
  - ONE: drain & ~accept → EMPTY.
  - ONE: accept & drain → ONE, head ← input.
  - TWO: drain → ONE, head ← skid. No accept is possible because in_ready=0.
- Outputs:
  - in_ready = (state ≠ TWO).
  - out_valid = (state ≠ EMPTY).
- Gating: out_mwe and out_rwe are forced 0 when out_valid=0, so bubbles never write memory or registers. Payload outputs keep their last stored values.
- Priority: rst > flush > stall > handshake.
  - flush: state → EMPTY next cycle. A concurrent in_valid is dropped.
  - stall: no state or payload change, regardless of in_valid or out_ready.
- Entry ordering is strict FIFO. Entries are never reordered or duplicated.

## Timing
- Reset (after one clk edge with rst=1):
  - state=EMPTY, so out_valid=0 and in_ready=1.
  - out_mwe=out_rwe=out_mux=fwd_rwe=0.
  - out_res=out_datb=0, out_creg=0.
  - rst mid-transfer discards both entries.
- Latency: accept in cycle N → out_valid=1 with that payload in cycle N+1.
- Throughput: 1 per cycle while out_ready=1.
- Backpressure: the first out_ready=0 cycle is absorbed by the skid entry. in_ready falls one cycle later (registered). An entry offered during the fall cycle is still accepted.
- Full with simultaneous drain: in_ready stays 0 in that cycle and rises in the next.
- Flush with simultaneous drain: flush wins. MEM must treat the head in that cycle as not consumed.
- Arithmetic: no arithmetic. All fields pass through bit-exact at any DATA_W or REG_W.

## Structure
- Package ex_mem_pkg:
  - typedef ex_mem_entry_t, a packed struct of the six fields, widths from package constants defaulting to 16/8;
  - enum occ_state_t {EMPTY, ONE, TWO}.
- Sub-module pipe_skid_buffer (parameter PAYLOAD_W):
  - generic 2-entry valid/ready skid with stall and flush;
  - the top level packs and unpacks ex_mem_entry_t and derives the gating and forwarding outputs.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1, in_mwe=1 → out_valid=0, out_mwe=0, out_res=0, in_ready=1. The first accepted entry after rst falls appears one cycle later.
- Streaming: 8 back-to-back entries, res=0x1000+i, out_ready=1 → each appears exactly one cycle after acceptance, in order, no gaps.
- Backpressure:
  - Drop out_ready for 3 cycles during a stream → exactly 2 entries held, in_ready=0 from the second stalled cycle.
  - Release → entries emerge in order, none lost or duplicated.
- Flush: with TWO entries held (mwe=1, rwe=1), pulse flush alongside in_valid=1 → next cycle out_valid=0, out_mwe=out_rwe=0, in_ready=1, incoming entry dropped.
- Stall: freeze 4 cycles while toggling in_valid and out_ready → state and outputs unchanged. Flow resumes with the identical head.
- Forwarding:
  - Head {rwe=1, mux=0, creg=0x05, res=0xBEEF} → fwd_rwe=1, fwd_reg=0x05, fwd_data=0xBEEF.
  - Same head with mux=1 → fwd_rwe=0.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared types for the EX->MEM pipeline stage.
// Entry layout and occupancy encoding.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 8;

  typedef struct packed {
    logic                  mwe;
    logic                  mux;
    logic                  rwe;
    logic [DATA_W_DEF-1:0] res;
    logic [DATA_W_DEF-1:0] datb;
    logic [REG_W_DEF-1:0]  creg;
  } ex_mem_entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready skid buffer with stall and flush.
// in_ready is a pure function of the registered occupancy.
module pipe_skid_buffer
  import ex_mem_pkg::*;
#(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_data
);

  occ_state_t state, state_nxt;
  logic [PAYLOAD_W-1:0] head, skid;
  logic acc, drn;
  logic head_from_in, head_from_skid, skid_ld;

  assign acc = in_valid & in_ready & ~stall & ~flush;
  assign drn = out_valid & out_ready & ~stall & ~flush;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (acc) state_nxt = ONE;
        ONE: begin
          if (acc && !drn)      state_nxt = TWO;
          else if (drn && !acc) state_nxt = EMPTY;
        end
        TWO:     if (drn) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    unique case (state)
      EMPTY: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
      ONE: begin
        in_ready  = 1'b1;
        out_valid = 1'b1;
      end
      TWO: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
      end
      default: begin
        in_ready  = 1'b1;
        out_valid = 1'b0;
      end
    endcase
  end

  // acc/drn already exclude stall and flush, so payload holds then
  assign head_from_in   = acc & ((state == EMPTY) |
                                 ((state == ONE) & drn));
  assign head_from_skid = drn & (state == TWO);
  assign skid_ld        = acc & ~drn & (state == ONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      skid <= '0;
    end else begin
      if (head_from_skid)    head <= skid;
      else if (head_from_in) head <= in_data;
      if (skid_ld)           skid <= in_data;
    end
  end

  assign out_data = head;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline stage: skid-buffered handshake, flush, forwarding tap.
// Packs the entry fields, then gates enables and derives forwarding.
module ex_mem_pipe_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mwe,
  input  logic              in_mux,
  input  logic              in_rwe,
  input  logic [DATA_W-1:0] in_res,
  input  logic [DATA_W-1:0] in_datb,
  input  logic [REG_W-1:0]  in_creg,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mwe,
  output logic              out_rwe,
  output logic              out_mux,
  output logic [DATA_W-1:0] out_res,
  output logic [DATA_W-1:0] out_datb,
  output logic [REG_W-1:0]  out_creg,
  output logic              fwd_rwe,
  output logic [REG_W-1:0]  fwd_reg,
  output logic [DATA_W-1:0] fwd_data
);

  localparam int PW = 3 + 2 * DATA_W + REG_W;

  logic [PW-1:0] in_data, head;
  logic h_mwe, h_rwe;

  // same field order as ex_mem_entry_t
  assign in_data = {in_mwe, in_mux, in_rwe,
                    in_res, in_datb, in_creg};

  pipe_skid_buffer #(
    .PAYLOAD_W(PW)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign {h_mwe, out_mux, h_rwe,
          out_res, out_datb, out_creg} = head;

  assign out_mwe  = out_valid & h_mwe;
  assign out_rwe  = out_valid & h_rwe;
  assign fwd_rwe  = out_valid & h_rwe & ~out_mux;
  assign fwd_reg  = out_creg;
  assign fwd_data = out_res;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Bench for ex_mem_pipe_stage: queue model plus directed vectors.
// Compares every negedge once reset has been applied.
module tb_ex_mem_pipe_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic        in_mwe, in_mux, in_rwe;
  logic [15:0] in_res, in_datb;
  logic [7:0]  in_creg;
  logic        stall, flush;
  logic        out_valid, out_ready;
  logic        out_mwe, out_rwe, out_mux;
  logic [15:0] out_res, out_datb;
  logic [7:0]  out_creg;
  logic        fwd_rwe;
  logic [7:0]  fwd_reg;
  logic [15:0] fwd_data;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  ex_mem_entry_t q[$];
  ex_mem_entry_t last_head;

  always #5 clk = ~clk;

  ex_mem_pipe_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mwe(in_mwe), .in_mux(in_mux), .in_rwe(in_rwe),
    .in_res(in_res), .in_datb(in_datb), .in_creg(in_creg),
    .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_mwe(out_mwe), .out_rwe(out_rwe), .out_mux(out_mux),
    .out_res(out_res), .out_datb(out_datb), .out_creg(out_creg),
    .fwd_rwe(fwd_rwe), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
  );

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  // FIFO of at most two entries; head payload persists when empty
  always @(posedge clk) begin
    bit acc, drn;
    ex_mem_entry_t e;
    e = '{mwe: in_mwe, mux: in_mux, rwe: in_rwe,
          res: in_res, datb: in_datb, creg: in_creg};
    if (rst) begin
      q.delete();
      last_head = '0;
    end else if (flush) begin
      q.delete();
    end else if (!stall) begin
      acc = in_valid && (q.size() < 2);
      drn = (q.size() > 0) && out_ready;
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
      if (q.size() > 0) last_head = q[0];
    end
  end

  always @(negedge clk) begin
    bit v;
    if (chk_on) begin
      v = (q.size() > 0);
      check("m_in_ready", in_ready, q.size() < 2);
      check("m_out_valid", out_valid, v);
      check("m_enables", {out_mwe, out_rwe},
            {v & last_head.mwe, v & last_head.rwe});
      check("m_payload",
            {out_mux, out_res, out_datb, out_creg},
            {last_head.mux, last_head.res,
             last_head.datb, last_head.creg});
      check("m_fwd", {fwd_rwe, fwd_reg, fwd_data},
            {v & last_head.rwe & ~last_head.mux,
             last_head.creg, last_head.res});
    end
  end

  function automatic ex_mem_entry_t mk(
    input logic mwe, input logic mux, input logic rwe,
    input logic [15:0] res, input logic [15:0] datb,
    input logic [7:0] creg);
    mk = '{mwe: mwe, mux: mux, rwe: rwe,
           res: res, datb: datb, creg: creg};
  endfunction

  task automatic drv(input logic v, input ex_mem_entry_t e,
                     input logic ordy, input logic stl,
                     input logic fl, input logic r);
    in_valid  = v;
    in_mwe    = e.mwe;
    in_mux    = e.mux;
    in_rwe    = e.rwe;
    in_res    = e.res;
    in_datb   = e.datb;
    in_creg   = e.creg;
    out_ready = ordy;
    stall     = stl;
    flush     = fl;
    rst       = r;
    @(negedge clk);
  endtask

  initial begin
    ex_mem_entry_t e;
    int k;
    bit a;
    e = mk(1, 0, 1, 16'h5555, 16'h6666, 8'h77);
    drv(1, e, 1, 0, 0, 1);
    drv(1, e, 1, 0, 0, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_mwe", out_mwe, 0);
    check("rst_out_res", out_res, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_fwd_rwe", fwd_rwe, 0);
    chk_on = 1'b1;

    // first entry after reset, then back-to-back stream
    for (int i = 0; i < 8; i++) begin
      e = mk(i[0], 0, 1, 16'h1000 + 16'(i),
             16'hA000 + 16'(i), 8'(i));
      drv(1, e, 1, 0, 0, 0);
      check("stream_valid", out_valid, 1);
      check("stream_res", out_res, 16'h1000 + 16'(i));
    end
    drv(0, e, 1, 0, 0, 0);
    check("stream_drained", out_valid, 0);

    // backpressure: out_ready low for cycles 2..4
    k = 0;
    for (int c = 0; c < 10; c++) begin
      e = mk(0, 0, 1, 16'h2000 + 16'(k), 16'h3000 + 16'(k), 8'(k));
      a = (k < 4) && in_ready;
      drv(k < 4, e, !(c >= 2 && c <= 4), 0, 0, 0);
      if (a) k++;
      if (c == 2) begin
        check("bp_ready_fall", in_ready, 0);
        check("bp_head", out_res, 16'h2001);
      end
      if (c == 5) begin
        check("bp_ready_rise", in_ready, 1);
        check("bp_head_next", out_res, 16'h2002);
      end
    end
    check("bp_all_taken", k, 4);

    // flush with two entries held, concurrent input dropped
    drv(1, mk(1, 0, 1, 16'h4000, 16'h0, 8'h1), 0, 0, 0, 0);
    drv(1, mk(1, 0, 1, 16'h4001, 16'h0, 8'h2), 0, 0, 0, 0);
    check("fl_full", in_ready, 0);
    drv(1, mk(1, 0, 1, 16'h4002, 16'h0, 8'h3), 1, 0, 1, 0);
    check("fl_valid", out_valid, 0);
    check("fl_en", {out_mwe, out_rwe}, 2'b00);
    check("fl_ready", in_ready, 1);
    drv(0, e, 1, 0, 0, 0);
    check("fl_dropped", out_valid, 0);

    // stall while full, inputs toggling
    drv(1, mk(0, 1, 1, 16'h5000, 16'h1, 8'h9), 0, 0, 0, 0);
    drv(1, mk(0, 0, 1, 16'h5001, 16'h2, 8'hA), 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      drv(c[0], mk(1, 0, 1, 16'h5100, 16'h3, 8'hB),
          !c[0], 1, 0, 0);
      check("st_head", out_res, 16'h5000);
      check("st_ready", in_ready, 0);
    end
    drv(0, e, 1, 0, 0, 0);
    check("st_resume", out_res, 16'h5001);
    drv(0, e, 1, 0, 0, 0);

    // forwarding tap
    drv(1, mk(0, 0, 1, 16'hBEEF, 16'h0, 8'h05), 0, 0, 0, 0);
    check("fwd_rwe_alu", fwd_rwe, 1);
    check("fwd_reg", fwd_reg, 8'h05);
    check("fwd_data", fwd_data, 16'hBEEF);
    drv(1, mk(0, 1, 1, 16'hBEEF, 16'h0, 8'h05), 1, 0, 0, 0);
    check("fwd_rwe_mem", fwd_rwe, 0);
    check("fwd_valid_mem", out_valid, 1);

    // reset mid-transfer discards both entries
    drv(1, mk(1, 0, 1, 16'h6000, 16'h0, 8'h1), 0, 0, 0, 0);
    drv(1, mk(1, 0, 1, 16'h6001, 16'h0, 8'h2), 0, 0, 0, 1);
    check("rst2_valid", out_valid, 0);
    check("rst2_res", out_res, 0);
    drv(0, e, 1, 0, 0, 0);
    drv(0, e, 1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
